// File: rtl/atm_keypad_entry_if.sv
// atm_keypad_entry_if: keypad strobe in, one complete ATM transaction request out.
// The master side drives keys and txn_ready; the slave (entry block) drives the request.
interface atm_keypad_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        txn_ready;
    logic        txn_valid;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] amount;
    logic [15:0] new_pin;
    logic        language;
    logic [2:0]  entry_state;
    logic [2:0]  digit_count;
    logic        err;
    modport master (
        output key_valid, key_code, txn_ready,
        input  txn_valid, operation, acc_num, pin, amount, new_pin, language,
               entry_state, digit_count, err
    );
    modport slave (
        input  key_valid, key_code, txn_ready,
        output txn_valid, operation, acc_num, pin, amount, new_pin, language,
               entry_state, digit_count, err
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: keypad keystrokes to one ATM request (account, PIN, operation, amount/new PIN).
// Optional idle-keystroke timeout under macro ENTRY_TIMEOUT_EN.
module atm_keypad_entry #(
    parameter int AMT_DIGITS     = 5,
    parameter int PIN_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic               clk,
    input logic               rst_n,
    atm_keypad_entry_if.slave io_bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ACC = 3'd1, S_PIN = 3'd2, S_OP = 3'd3,
        S_AMT = 3'd4, S_NEWPIN = 3'd5, S_SEND = 3'd6
    } state_t;

    state_t      r_state;
    logic [3:0]  r_acc;
    logic [15:0] r_pin, r_newpin, r_amt;
    logic [2:0]  r_op, r_cnt;
    logic        r_lang, r_err, r_valid;

    logic        w_digit, w_enter, w_clear, w_cancel, w_lang, w_in_entry, w_timeout, w_abort;
    logic [3:0]  w_d;
    logic [7:0]  w_acc_next;
    logic [19:0] w_amt_next;
    logic [15:0] w_nib;

    assign w_d        = io_bus.key_code;
    assign w_digit    = io_bus.key_valid && w_d <= 4'd9;
    assign w_enter    = io_bus.key_valid && w_d == 4'hA;
    assign w_cancel   = io_bus.key_valid && w_d == 4'hB;
    assign w_clear    = io_bus.key_valid && w_d == 4'hC;
    assign w_lang     = io_bus.key_valid && w_d == 4'hD;
    assign w_in_entry = r_state inside {S_ACC, S_PIN, S_OP, S_AMT, S_NEWPIN};
    assign w_acc_next = {4'd0, r_acc} * 8'd10 + {4'd0, w_d};
    assign w_amt_next = {4'd0, r_amt} * 20'd10 + {16'd0, w_d};
    // Digit placed at the nibble for its position, so the first digit always sits in [15:12]
    assign w_nib      = {w_d, 12'd0} >> {r_cnt[1:0], 2'b00};

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmr;
    assign w_timeout = w_in_entry && !io_bus.key_valid && r_tmr == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tmr <= '0;
        else r_tmr <= (w_in_entry && !io_bus.key_valid && !w_timeout) ? r_tmr + 1'b1 : '0;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // SEND leaves only through the handshake; every other state leaves on CANCEL or timeout
    assign w_abort = (r_state == S_SEND) ? io_bus.txn_ready : (w_cancel || w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_pin    <= '0;
            r_newpin <= '0;
            r_amt    <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_lang   <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_abort) begin
                r_state  <= S_IDLE;
                r_acc    <= '0;
                r_pin    <= '0;
                r_newpin <= '0;
                r_amt    <= '0;
                r_op     <= '0;
                r_cnt    <= '0;
                r_valid  <= 1'b0;
                r_err    <= w_timeout;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_digit) begin
                            r_acc   <= w_d;
                            r_cnt   <= 3'd1;
                            r_state <= S_ACC;
                        end else if (w_lang) r_lang <= ~r_lang;
                    end
                    S_ACC: begin
                        if (w_digit) begin
                            if (r_cnt < 3'd2 && w_acc_next <= 8'd15) begin
                                r_acc <= w_acc_next[3:0];
                                r_cnt <= r_cnt + 3'd1;
                            end else r_err <= 1'b1;
                        end else if (w_enter) begin
                            if (r_cnt != 3'd0) begin
                                r_state <= S_PIN;
                                r_cnt   <= '0;
                            end else r_err <= 1'b1;
                        end else if (w_clear) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end
                    end
                    S_PIN, S_NEWPIN: begin
                        if (w_digit) begin
                            if (r_cnt < 3'(PIN_DIGITS)) begin
                                if (r_state == S_PIN) r_pin <= r_pin | w_nib;
                                else r_newpin <= r_newpin | w_nib;
                                r_cnt <= r_cnt + 3'd1;
                            end else r_err <= 1'b1;
                        end else if (w_enter) begin
                            if (r_cnt == 3'(PIN_DIGITS)) begin
                                r_state <= (r_state == S_PIN) ? S_OP : S_SEND;
                                r_valid <= r_state == S_NEWPIN;
                                r_cnt   <= '0;
                            end else r_err <= 1'b1;
                        end else if (w_clear) begin
                            if (r_state == S_PIN) r_pin <= '0;
                            else r_newpin <= '0;
                            r_cnt <= '0;
                        end
                    end
                    S_OP: begin
                        if (w_digit) begin
                            if (w_d >= 4'd1 && w_d <= 4'd4) begin
                                r_op  <= w_d[2:0];
                                r_cnt <= 3'd1;
                            end else r_err <= 1'b1;
                        end else if (w_enter) begin
                            if (r_op != 3'd0) begin
                                r_state <= (r_op == 3'd1) ? S_SEND : (r_op == 3'd4) ? S_NEWPIN : S_AMT;
                                r_valid <= r_op == 3'd1;
                                r_cnt   <= '0;
                            end else r_err <= 1'b1;
                        end else if (w_clear) begin
                            r_op  <= '0;
                            r_cnt <= '0;
                        end
                    end
                    S_AMT: begin
                        if (w_digit) begin
                            if (r_cnt < 3'(AMT_DIGITS) && w_amt_next <= 20'd65535) begin
                                r_amt <= w_amt_next[15:0];
                                r_cnt <= r_cnt + 3'd1;
                            end else r_err <= 1'b1;
                        end else if (w_enter) begin
                            if (r_amt != 16'd0) begin
                                r_state <= S_SEND;
                                r_valid <= 1'b1;
                                r_cnt   <= '0;
                            end else r_err <= 1'b1;
                        end else if (w_clear) begin
                            r_amt <= '0;
                            r_cnt <= '0;
                        end
                    end
                    S_SEND: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign io_bus.txn_valid   = r_valid;
    assign io_bus.operation   = r_op;
    assign io_bus.acc_num     = r_acc;
    assign io_bus.pin         = r_pin;
    assign io_bus.amount      = r_amt;
    assign io_bus.new_pin     = r_newpin;
    assign io_bus.language    = r_lang;
    assign io_bus.entry_state = r_state;
    assign io_bus.digit_count = r_cnt;
    assign io_bus.err         = r_err;
endmodule

// File: tb/tb_atm_keypad_entry.sv
// tb_atm_keypad_entry: directed keystroke sequences against hand-computed request fields.
module tb_atm_keypad_entry;
    localparam logic [3:0] ENT = 4'hA, CAN = 4'hB, CLR = 4'hC, LNG = 4'hD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    atm_keypad_entry_if bus ();
    atm_keypad_entry dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

    always #5 clk = ~clk;

    logic [63:0] w_all;
    assign w_all = {bus.txn_valid, bus.operation, bus.acc_num, bus.pin, bus.amount, bus.new_pin,
                    bus.language, bus.entry_state, bus.digit_count, bus.err};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    // Presses n keys, taken from the most significant used nibble downward
    task automatic keys(input logic [63:0] seq, input int n);
        for (int i = 0; i < n; i++) press(seq[4*(n-1-i) +: 4]);
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.txn_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_all", w_all, 64'd0);
        rst_n = 1'b1;

        press(LNG);
        chk("lang_toggle", bus.language, 1);
        chk("lang_no_err", bus.err, 0);
        press(CAN);
        chk("lang_after_cancel", bus.language, 1);

        bus.txn_ready = 1'b1;
        keys(64'h12A4321A2A500A, 14);
        chk("t1_valid", bus.txn_valid, 1);
        chk("t1_state", bus.entry_state, 6);
        chk("t1_acc", bus.acc_num, 12);
        chk("t1_pin", bus.pin, 16'h4321);
        chk("t1_op", bus.operation, 2);
        chk("t1_amt", bus.amount, 500);
        @(negedge clk);
        chk("t1_valid_drop", bus.txn_valid, 0);
        chk("t1_idle", bus.entry_state, 0);
        chk("t1_fields_clear", {bus.operation, bus.acc_num, bus.pin, bus.amount, bus.new_pin, bus.digit_count}, 0);
        chk("t1_lang_kept", bus.language, 1);
        bus.txn_ready = 1'b0;

        press(1); press(6);
        chk("acc_16_err", bus.err, 1);
        chk("acc_16_keep", bus.acc_num, 1);
        press(5);
        chk("acc_15", {bus.acc_num, bus.digit_count, bus.err}, {4'd15, 3'd2, 1'b0});
        press(0);
        chk("acc_third_err", bus.err, 1);
        press(CLR);
        chk("acc_clear", {bus.acc_num, bus.digit_count, bus.entry_state}, {4'd0, 3'd0, 3'd1});
        press(CAN);
        chk("acc_cancel", bus.entry_state, 0);

        keys(64'h1A123A, 6);
        chk("pin_short_err", bus.err, 1);
        chk("pin_short_state", bus.entry_state, 2);
        chk("pin_short_cnt", bus.digit_count, 3);
        press(LNG);
        chk("lang_ignored", {bus.language, bus.err}, {1'b1, 1'b0});
        press(4); press(ENT);
        chk("pin_to_op", bus.entry_state, 3);
        press(ENT);
        chk("op_none_err", {bus.err, bus.entry_state}, {1'b1, 3'd3});
        press(5);
        chk("op_5_err", {bus.err, bus.operation}, {1'b1, 3'd0});
        press(3); press(2);
        chk("op_overwrite", bus.operation, 2);
        press(4'hE);
        chk("key_e_ignored", {bus.err, bus.operation, bus.entry_state}, {1'b0, 3'd2, 3'd3});
        press(ENT);
        chk("op_to_amt", bus.entry_state, 4);

        keys(64'h65535, 5);
        chk("amt_max", {bus.amount, bus.digit_count}, {16'd65535, 3'd5});
        press(9);
        chk("amt_6th_err", {bus.err, bus.amount}, {1'b1, 16'd65535});
        press(CLR);
        chk("amt_clear", {bus.amount, bus.digit_count}, 0);
        keys(64'h6553, 4);
        press(6);
        chk("amt_ovf_err", {bus.err, bus.amount}, {1'b1, 16'd6553});

        press(ENT);
        chk("send_enter", {bus.txn_valid, bus.entry_state}, {1'b1, 3'd6});
        for (int i = 0; i < 5; i++) press((i % 2 == 0) ? CAN : 4'd7);
        chk("send_hold", {bus.txn_valid, bus.entry_state, bus.amount, bus.acc_num, bus.err},
            {1'b1, 3'd6, 16'd6553, 4'd1, 1'b0});
        bus.txn_ready = 1'b1;
        @(negedge clk);
        chk("send_release", {bus.txn_valid, bus.entry_state, bus.amount}, 0);
        bus.txn_ready = 1'b0;

        keys(64'h3A1111A4A9876A, 14);
        chk("op4_send", {bus.txn_valid, bus.entry_state, bus.operation}, {1'b1, 3'd6, 3'd4});
        chk("op4_newpin", bus.new_pin, 16'h9876);
        chk("op4_fields", {bus.acc_num, bus.pin, bus.amount}, {4'd3, 16'h1111, 16'd0});
        bus.txn_ready = 1'b1;
        @(negedge clk);
        chk("op4_release", {bus.txn_valid, bus.entry_state, bus.language}, {1'b0, 3'd0, 1'b1});
        bus.txn_ready = 1'b0;

        keys(64'h1A43, 4);
        chk("mid_pin_cnt", {bus.entry_state, bus.digit_count}, {3'd2, 3'd2});
        #2 rst_n = 1'b0;
        #1 chk("async_reset", w_all, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
